// File: rtl/x_lut_k_bit_multi.sv
// K-input, W-output lookup-table cell with a serially loaded shadow store
// and an atomic commit into the active store. The chain output lets several
// cells be daisy-chained on one config line.
module x_lut_k_bit_multi #(
    parameter int unsigned K       = 4,
    parameter int unsigned W       = 2,
    parameter int unsigned REG_OUT = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_chain_data,
    input  logic         i_chain_en,
    output logic         o_chain_data,
    input  logic         i_commit,
    output logic         o_cfg_full,
    output logic         o_cfg_err,
    input  logic [K-1:0] i_in,
    output logic [W-1:0] o_out
);

    // Table depth per output, total config bits, counter and index widths.
    localparam int unsigned T  = 2 ** K;
    localparam int unsigned D  = W * T;
    localparam int unsigned CW = $clog2(D + 1);
    localparam int unsigned AW = $clog2(D);

    logic [D-1:0]  shadow_q;
    logic [D-1:0]  shadow_d;
    logic [D-1:0]  active_q;
    logic [D-1:0]  active_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          cfg_full_q;
    logic          cfg_full_d;
    logic          cfg_err_q;
    logic          cfg_err_d;
    logic          commit_ok;
    logic [W-1:0]  raw;
    logic [AW-1:0] idx;

    // Next-state for the config path: shift, saturating count, commit, error.
    always_comb begin
        shadow_d   = shadow_q;
        active_d   = active_q;
        count_d    = count_q;
        cfg_err_d  = 1'b0;
        commit_ok  = i_commit & cfg_full_q;

        if (i_chain_en) begin
            shadow_d = {shadow_q[D-2:0], i_chain_data};
        end

        if (commit_ok) begin
            // Commit takes the pre-shift shadow; a simultaneous shift starts a new load.
            active_d = shadow_q;
            count_d  = i_chain_en ? CW'(1) : CW'(0);
        end else if (i_chain_en) begin
            count_d = (count_q == CW'(D)) ? count_q : count_q + CW'(1);
        end

        if (i_commit && !cfg_full_q) begin
            cfg_err_d = 1'b1;
        end

        cfg_full_d = (count_d == CW'(D));
    end

    // Config state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow_q   <= '0;
            active_q   <= '0;
            count_q    <= '0;
            cfg_full_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            count_q    <= count_d;
            cfg_full_q <= cfg_full_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign o_chain_data = shadow_q[D-1];
    assign o_cfg_full   = cfg_full_q;
    assign o_cfg_err    = cfg_err_q;

    // Table lookup: output w reads its own 2**K slice of the active store.
    always_comb begin
        raw = '0;
        idx = '0;
        for (int w = 0; w < int'(W); w++) begin
            idx    = AW'(AW'(w) << K) + AW'(i_in);
            raw[w] = active_q[idx];
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [W-1:0] out_q;

            // Pipelined output stage.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    out_q <= '0;
                end else begin
                    out_q <= raw;
                end
            end

            assign o_out = out_q;
        end else begin : g_comb_out
            assign o_out = raw;
        end
    endgenerate

endmodule
